// File: rtl/framebuffer_access_arbiter.sv
// Arbitrates the framebuffer RAM port between single-word core accesses and video read bursts,
// and routes read returns to their owner through a tag pipe matched to the RAM read latency.
module framebuffer_access_arbiter #(
  parameter int ADDR_WIDTH   = 17,
  parameter int BURST_LEN    = 8,
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [31:0]           core_wdata,
  input  logic [3:0]            core_be,
  output logic                  core_ack,
  output logic [31:0]           core_rdata,
  output logic                  core_rvalid,
  input  logic                  vid_req,
  input  logic                  vid_urgent,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_grant,
  output logic [31:0]           vid_rdata,
  output logic                  vid_rvalid,
  output logic                  vid_last,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [31:0]           mem_rdata
);

  localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 2);
  localparam logic OWN_CORE = 1'b1;
  localparam logic OWN_VID  = 1'b0;

  typedef enum logic [1:0] {IDLE, CORE, VID} state_t;

  state_t              state;
  state_t              state_next;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [BEAT_W-1:0]   beat_next;
  logic [STARVE_W-1:0] starve_cnt;
  logic                last_owner;
  logic                rd_owner;
  logic                rd_last;
  logic [2:0]          tag_pipe [READ_LATENCY];
  logic [2:0]          tag_out;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (core_req && (starve_cnt >= STARVE_W'(STARVE_LIMIT))) state_next = CORE;
        else if (vid_req && vid_urgent)                          state_next = VID;
        else if (core_req && vid_req)
          state_next = (last_owner == OWN_CORE) ? VID : CORE;
        else if (core_req)                                       state_next = CORE;
        else if (vid_req)                                        state_next = VID;
      end
      CORE:    state_next = IDLE;
      VID:     if (beat_cnt == BEAT_W'(BURST_LEN - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    core_ack  = (state == CORE);
    vid_grant = (state == VID) && (beat_cnt == '0);
  end

  assign beat_next = (state == VID && state_next == VID) ? beat_cnt + BEAT_W'(1) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) beat_cnt <= '0;
    else        beat_cnt <= beat_next;
  end

  // The RAM strobes are loaded one edge early, from the next-state decision, so they line up with core_ack/beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      rd_owner  <= OWN_VID;
      rd_last   <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      rd_owner <= OWN_VID;
      rd_last  <= 1'b0;
      if (state == IDLE && state_next == CORE) begin
        mem_addr  <= core_addr;
        mem_wdata <= core_wdata;
        mem_be    <= core_we ? core_be : 4'hF;
        mem_we    <= core_we;
        mem_re    <= !core_we;
        rd_owner  <= OWN_CORE;
      end else if (state_next == VID) begin
        mem_addr <= (state == IDLE) ? vid_addr : mem_addr + ADDR_WIDTH'(1);
        mem_be   <= 4'hF;
        mem_re   <= 1'b1;
        rd_last  <= (beat_next == BEAT_W'(BURST_LEN - 1));
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   starve_cnt <= '0;
    else if (!core_req || state == CORE) starve_cnt <= '0;
    else if (starve_cnt != {STARVE_W{1'b1}}) starve_cnt <= starve_cnt + STARVE_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                last_owner <= OWN_VID;
    else if (state == CORE)                    last_owner <= OWN_CORE;
    else if (state == VID && state_next == IDLE) last_owner <= OWN_VID;
  end

  // One tag per issue slot; the last stage coincides with mem_rdata for that slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_pipe[i] <= 3'b000;
    end else begin
      tag_pipe[0] <= {mem_re, rd_owner, rd_last};
      for (int i = 1; i < READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_out     = tag_pipe[READ_LATENCY-1];
  assign core_rvalid = tag_out[2] && (tag_out[1] == OWN_CORE);
  assign vid_rvalid  = tag_out[2] && (tag_out[1] == OWN_VID);
  assign vid_last    = vid_rvalid && tag_out[0];
  assign core_rdata  = core_rvalid ? mem_rdata : 32'h0;
  assign vid_rdata   = vid_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_framebuffer_access_arbiter.sv
// Directed bench for framebuffer_access_arbiter with a fixed-latency RAM model
// returning 0x7700_0000 | address as read data.
module tb_framebuffer_access_arbiter;

  localparam int AW = 17;
  localparam int BL = 8;
  localparam int RL = 2;
  localparam int SL = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          core_req = 1'b0;
  logic          core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [31:0]   core_wdata = '0;
  logic [3:0]    core_be = '0;
  logic          core_ack;
  logic [31:0]   core_rdata;
  logic          core_rvalid;
  logic          vid_req = 1'b0;
  logic          vid_urgent = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_grant;
  logic [31:0]   vid_rdata;
  logic          vid_rvalid;
  logic          vid_last;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_we;
  logic          mem_re;
  logic [31:0]   mem_rdata;

  int total = 0;
  int bad = 0;

  framebuffer_access_arbiter #(
    .ADDR_WIDTH(AW), .BURST_LEN(BL), .READ_LATENCY(RL), .STARVE_LIMIT(SL)
  ) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_be(core_be), .core_ack(core_ack),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .vid_req(vid_req), .vid_urgent(vid_urgent), .vid_addr(vid_addr),
    .vid_grant(vid_grant), .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .vid_last(vid_last),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // RAM model: data for an address appears RL cycles after it is presented.
  logic [AW-1:0] ram_pipe [RL];
  always @(posedge clock) begin
    ram_pipe[0] <= mem_addr;
    for (int i = 1; i < RL; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign mem_rdata = 32'h7700_0000 | {15'd0, ram_pipe[RL-1]};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({core_ack, core_rvalid, vid_grant, vid_rvalid, vid_last, mem_we, mem_re} !== 7'b0 ||
        mem_addr !== '0 || mem_wdata !== 32'h0 || mem_be !== 4'h0 ||
        core_rdata !== 32'h0 || vid_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got ack=%b re=%b we=%b addr=%h be=%h, want all 0",
               core_ack, mem_re, mem_we, mem_addr, mem_be);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_core_write();
    core_req = 1'b1; core_we = 1'b1; core_addr = 17'h00010;
    core_be = 4'b0011; core_wdata = 32'hDEADBEEF;
    tick();
    total++;
    if (core_ack !== 1'b1 || mem_we !== 1'b1 || mem_re !== 1'b0 || mem_be !== 4'b0011 ||
        mem_addr !== 17'h00010 || mem_wdata !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL t1_write_issue: got ack=%b we=%b re=%b be=%h addr=%h wdata=%h, want 1 1 0 3 00010 deadbeef",
               core_ack, mem_we, mem_re, mem_be, mem_addr, mem_wdata);
    end
    core_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (core_rvalid !== 1'b0 || core_ack !== 1'b0 || mem_we !== 1'b0) begin
        bad++;
        $display("[TB] FAIL t1_no_return: cycle %0d got rvalid=%b ack=%b we=%b, want 0 0 0",
                 c, core_rvalid, core_ack, mem_we);
      end
    end
  endtask

  task automatic test_core_read();
    core_req = 1'b1; core_we = 1'b0; core_addr = 17'h1FFFF; core_be = 4'b0001;
    tick();
    total++;
    if (core_ack !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF ||
        mem_addr !== 17'h1FFFF) begin
      bad++;
      $display("[TB] FAIL t2_read_issue: got ack=%b re=%b we=%b be=%h addr=%h, want 1 1 0 f 1ffff",
               core_ack, mem_re, mem_we, mem_be, mem_addr);
    end
    core_req = 1'b0;
    tick();
    total++;
    if (core_rvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL t2_early_rvalid: got %b want 0", core_rvalid);
    end
    tick();
    total++;
    if (core_rvalid !== 1'b1 || core_rdata !== 32'h7701FFFF || vid_rvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL t2_return: got rvalid=%b rdata=%h vid_rvalid=%b, want 1 7701ffff 0",
               core_rvalid, core_rdata, vid_rvalid);
    end
    tick();
    total++;
    if (core_rvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL t2_single_rvalid: got %b want 0", core_rvalid);
    end
  endtask

  task automatic test_contention();
    logic seq [4];
    int   ngrant = 0;
    int   vbeat = 0;
    int   ncore = 0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 17'h00100;
    vid_req = 1'b1; vid_urgent = 1'b0; vid_addr = 17'h00200;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if ((core_ack || vid_grant) && ngrant < 4) begin
        seq[ngrant] = core_ack;
        ngrant++;
      end
      if (core_rvalid) begin
        ncore++;
        total++;
        if (core_rdata !== 32'h7700_0100 || vid_rvalid !== 1'b0) begin
          bad++;
          $display("[TB] FAIL t4_core_return: got rdata=%h vid_rvalid=%b, want 77000100 0",
                   core_rdata, vid_rvalid);
        end
      end
      if (vid_rvalid) begin
        total++;
        if (vid_rdata !== (32'h7700_0200 | (vbeat % BL)) || vid_last !== ((vbeat % BL) == BL - 1)) begin
          bad++;
          $display("[TB] FAIL t4_vid_return: beat %0d got rdata=%h last=%b, want %h %b",
                   vbeat, vid_rdata, vid_last, 32'h7700_0200 | (vbeat % BL), (vbeat % BL) == BL - 1);
        end
        vbeat++;
      end
      if (ngrant == 4 || c == 30) begin
        core_req = 1'b0;
        vid_req = 1'b0;
      end
    end
    total++;
    if (ngrant != 4 || seq[0] !== 1'b0 || seq[1] !== 1'b1 || seq[2] !== 1'b0 || seq[3] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL t4_order: got %0d grants order core=%b%b%b%b, want 4 grants 0101",
               ngrant, seq[0], seq[1], seq[2], seq[3]);
    end
    total++;
    if (vbeat != 2 * BL || ncore != 2) begin
      bad++;
      $display("[TB] FAIL t4_return_count: got vid=%0d core=%0d, want 16 2", vbeat, ncore);
    end
  endtask

  task automatic test_burst_wrap();
    logic [AW-1:0] exp_addr [BL];
    int            nret = 0;
    exp_addr = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001,
                 17'h00002, 17'h00003, 17'h00004, 17'h00005};
    vid_req = 1'b1; vid_urgent = 1'b0; vid_addr = 17'h1FFFE;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) vid_req = 1'b0;
      if (c <= BL) begin
        total++;
        if (mem_re !== 1'b1 || mem_addr !== exp_addr[c-1] || vid_grant !== (c == 1)) begin
          bad++;
          $display("[TB] FAIL t3_beat%0d: got re=%b addr=%h grant=%b, want 1 %h %b",
                   c - 1, mem_re, mem_addr, vid_grant, exp_addr[c-1], c == 1);
        end
      end else if (c == BL + 1) begin
        total++;
        if (mem_re !== 1'b0) begin
          bad++;
          $display("[TB] FAIL t3_burst_end: got re=%b want 0", mem_re);
        end
      end
      total++;
      if (vid_rvalid !== (c >= 3 && c <= BL + 2) || core_rvalid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL t3_rvalid_c%0d: got vid=%b core=%b, want %b 0",
                 c, vid_rvalid, core_rvalid, c >= 3 && c <= BL + 2);
      end else if (vid_rvalid) begin
        total++;
        if (vid_rdata !== (32'h7700_0000 | {15'd0, exp_addr[c-3]}) || vid_last !== (c == BL + 2)) begin
          bad++;
          $display("[TB] FAIL t3_data_c%0d: got rdata=%h last=%b, want %h %b",
                   c, vid_rdata, vid_last, 32'h7700_0000 | {15'd0, exp_addr[c-3]}, c == BL + 2);
        end
        nret++;
      end
    end
    total++;
    if (nret != BL) begin
      bad++;
      $display("[TB] FAIL t3_count: got %0d returns want %0d", nret, BL);
    end
  endtask

  task automatic test_starvation();
    int ack_cycle = 0;
    int vgrants = 0;
    core_req = 1'b1; core_we = 1'b1; core_addr = 17'h00033;
    core_wdata = 32'h0000_1234; core_be = 4'hF;
    vid_req = 1'b1; vid_urgent = 1'b1; vid_addr = 17'h00400;
    for (int c = 1; c <= 40 && ack_cycle == 0; c++) begin
      tick();
      if (vid_grant) vgrants++;
      if (core_ack) begin
        ack_cycle = c;
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 17'h00033 || mem_wdata !== 32'h0000_1234) begin
          bad++;
          $display("[TB] FAIL t5_access: got we=%b addr=%h wdata=%h, want 1 00033 00001234",
                   mem_we, mem_addr, mem_wdata);
        end
      end
    end
    core_req = 1'b0;
    vid_req = 1'b0;
    vid_urgent = 1'b0;
    total++;
    if (ack_cycle != 19 || vgrants != 2) begin
      bad++;
      $display("[TB] FAIL t5_starve: got ack at cycle %0d after %0d video grants, want 19 and 2",
               ack_cycle, vgrants);
    end
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_reset_mid_burst();
    vid_req = 1'b1; vid_urgent = 1'b0; vid_addr = 17'h00500;
    tick();
    vid_req = 1'b0;
    total++;
    if (vid_grant !== 1'b1) begin
      bad++;
      $display("[TB] FAIL t6_grant: got %b want 1", vid_grant);
    end
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({core_ack, core_rvalid, vid_grant, vid_rvalid, vid_last, mem_we, mem_re} !== 7'b0 ||
        mem_addr !== '0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 ||
        vid_rdata !== 32'h0 || core_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL t6_async_clear: got re=%b addr=%h vid_rvalid=%b grant=%b, want all 0",
               mem_re, mem_addr, vid_rvalid, vid_grant);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (vid_rvalid !== 1'b0 || core_rvalid !== 1'b0 || mem_re !== 1'b0) begin
        bad++;
        $display("[TB] FAIL t6_no_stale: cycle %0d got vid_rvalid=%b core_rvalid=%b re=%b, want 0 0 0",
                 c, vid_rvalid, core_rvalid, mem_re);
      end
    end
    core_req = 1'b1; core_we = 1'b0; core_addr = 17'h00077;
    tick();
    core_req = 1'b0;
    total++;
    if (core_ack !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 17'h00077) begin
      bad++;
      $display("[TB] FAIL t6_regrant: got ack=%b re=%b addr=%h, want 1 1 00077",
               core_ack, mem_re, mem_addr);
    end
    tick();
    tick();
    total++;
    if (core_rvalid !== 1'b1 || core_rdata !== 32'h7700_0077) begin
      bad++;
      $display("[TB] FAIL t6_return: got rvalid=%b rdata=%h, want 1 77000077", core_rvalid, core_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_core_write();
    test_core_read();
    test_contention();
    test_burst_wrap();
    test_starvation();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
